// File: rtl/instruction_cache_if.sv
// ============================================================================
// Module      : instruction_cache_if
// Description : CPU fetch port and line-fill memory port of the instruction
//               cache. Stats outputs exist only when ICACHE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_cache_if #(
    parameter int WORD_SIZE = 16
);
    logic                 read_m1;
    logic [WORD_SIZE-1:0] address1;
    logic [WORD_SIZE-1:0] data1;
    logic                 i_ready;
    logic                 fence_i;
    logic                 mem_req;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_valid;
    logic [WORD_SIZE-1:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [15:0]          hit_count;
    logic [15:0]          miss_count;

    modport slave (
        input  read_m1, address1, fence_i, mem_valid, mem_rdata,
        output data1, i_ready, mem_req, mem_addr, hit_count, miss_count
    );
    modport master (
        output read_m1, address1, fence_i, mem_valid, mem_rdata,
        input  data1, i_ready, mem_req, mem_addr, hit_count, miss_count
    );
`else
    modport slave (
        input  read_m1, address1, fence_i, mem_valid, mem_rdata,
        output data1, i_ready, mem_req, mem_addr
    );
    modport master (
        output read_m1, address1, fence_i, mem_valid, mem_rdata,
        input  data1, i_ready, mem_req, mem_addr
    );
`endif
endinterface

`default_nettype wire

// File: rtl/instruction_cache.sv
// ============================================================================
// Module      : instruction_cache
// Description : Direct-mapped read-only instruction cache with whole-line fill.
//               Optional hit/miss counters enabled by ICACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_cache #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    instruction_cache_if.slave  bus
);
    localparam int c_off = $clog2(LINE_WORDS);
    localparam int c_idx = $clog2(NUM_LINES);
    localparam int c_tag = WORD_SIZE - c_off - c_idx;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [c_off-1:0]       beat_q, beat_d;
    logic [WORD_SIZE-1:0]   base_q, base_d;
    logic                   poison_q, poison_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [c_tag-1:0]       tag_q  [NUM_LINES];
    logic [WORD_SIZE-1:0]   data_q [NUM_LINES][LINE_WORDS];

    logic [c_off-1:0]       w_req_off;
    logic [c_idx-1:0]       w_req_idx;
    logic [c_tag-1:0]       w_req_tag;
    logic [c_idx-1:0]       w_fill_idx;
    logic [c_tag-1:0]       w_fill_tag;
    logic                   w_hit;
    logic                   w_data_we;
    logic                   w_tag_we;
    logic                   w_miss_start;

    always_comb begin
        w_req_off  = bus.address1[c_off-1:0];
        w_req_idx  = bus.address1[c_off+c_idx-1:c_off];
        w_req_tag  = bus.address1[WORD_SIZE-1:c_off+c_idx];
        w_fill_idx = base_q[c_off+c_idx-1:c_off];
        w_fill_tag = base_q[WORD_SIZE-1:c_off+c_idx];
        w_hit      = bus.read_m1 && valid_q[w_req_idx] &&
                     (tag_q[w_req_idx] == w_req_tag) && (state_q == S_IDLE);
    end

    // The CPU is stalled for the whole fill, even if it drops its request.
    assign bus.i_ready  = (state_q == S_IDLE) && (!bus.read_m1 || w_hit);
    assign bus.data1    = w_hit ? data_q[w_req_idx][w_req_off] : '0;
    assign bus.mem_req  = (state_q == S_FILL);
    assign bus.mem_addr = base_q;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        poison_d     = poison_q;
        valid_d      = valid_q;
        w_data_we    = 1'b0;
        w_tag_we     = 1'b0;
        w_miss_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.fence_i) begin
                    valid_d = '0;
                end
                if (bus.read_m1 && !w_hit) begin
                    state_d      = S_FILL;
                    base_d       = {w_req_tag, w_req_idx, {c_off{1'b0}}};
                    beat_d       = '0;
                    poison_d     = 1'b0;
                    w_miss_start = 1'b1;
                end
            end
            S_FILL: begin
                if (bus.fence_i) begin
                    valid_d  = '0;
                    poison_d = 1'b1;
                end
                if (bus.mem_valid) begin
                    w_data_we = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    // A fence in the final beat cycle must still poison the line.
                    if (beat_q == {c_off{1'b1}}) begin
                        state_d = S_IDLE;
                        if (!(poison_q || bus.fence_i)) begin
                            w_tag_we            = 1'b1;
                            valid_d[w_fill_idx] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            base_q   <= '0;
            poison_q <= 1'b0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            poison_q <= poison_d;
            valid_q  <= valid_d;
        end
    end

    // Storage arrays carry no reset; the valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (w_data_we) begin
            data_q[w_fill_idx][beat_q] <= bus.mem_rdata;
        end
        if (w_tag_we) begin
            tag_q[w_fill_idx] <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (w_hit && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (w_miss_start && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_cache.sv
// ============================================================================
// Module      : tb_instruction_cache
// Description : Directed and randomized fetch stimulus against a line-level
//               reference model of the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_cache;
    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 8;

    logic clk = 1'b0;
    logic reset_n;

    instruction_cache_if #(.WORD_SIZE(WORD_SIZE)) bus ();

    instruction_cache #(
        .WORD_SIZE (WORD_SIZE),
        .LINE_WORDS(LINE_WORDS),
        .NUM_LINES (NUM_LINES)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mem [256];
    int          ref_base [NUM_LINES];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [15:0] a);
        int line;
        line = (int'(a) / LINE_WORDS) % NUM_LINES;
        return ref_base[line] == (int'(a) - int'(a) % LINE_WORDS);
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < NUM_LINES; i++) ref_base[i] = -1;
    endfunction

    // One CPU fetch until it is served; optional redirect, fence or reset during the first fill.
    task automatic fetch(input logic [15:0] a, input int lat, input bit gaps,
                         input int redir_beat, input logic [15:0] redir_a,
                         input int fence_beat, input int rst_beat, output int stalls);
        logic [15:0] cur;
        cur    = a;
        stalls = 0;
        bus.read_m1   = 1'b1;
        bus.address1  = a;
        bus.fence_i   = 1'b0;
        bus.mem_valid = 1'b0;
        for (int pass = 0; pass < 4; pass++) begin
            int base;
            int line;
            bit poison;
            @(negedge clk);
            if (pass > 0) check("req_drop", bus.mem_req, 0);
            if (model_hit(cur)) begin
                check("hit_ready", bus.i_ready, 1);
                check("hit_data", bus.data1, mem[cur[7:0]]);
                check("hit_req", bus.mem_req, 0);
                exp_hits++;
                @(posedge clk); #1;
                bus.read_m1 = 1'b0;
                return;
            end
            check("miss_ready", bus.i_ready, 0);
            check("miss_data", bus.data1, 0);
            stalls++;
            base   = int'(cur) - int'(cur) % LINE_WORDS;
            line   = (int'(cur) / LINE_WORDS) % NUM_LINES;
            poison = 1'b0;
            exp_misses++;
            @(posedge clk); #1;
            for (int l = 0; l < lat; l++) begin
                @(negedge clk);
                check("lat_req", bus.mem_req, 1);
                check("lat_addr", bus.mem_addr, base);
                check("lat_ready", bus.i_ready, 0);
                stalls++;
                @(posedge clk); #1;
            end
            for (int b = 0; b < LINE_WORDS; b++) begin
                if (pass == 0 && b == rst_beat) begin
                    reset_n = 1'b0;
                    #1;
                    check("rst_req", bus.mem_req, 0);
                    check("rst_ready", bus.i_ready, 0);
                    model_flush();
                    exp_hits   = 0;
                    exp_misses = 0;
                    @(posedge clk); #1;
                    reset_n     = 1'b1;
                    bus.read_m1 = 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        bus.mem_valid = 1'b1;
                        bus.mem_rdata = 16'hDEAD;
                        @(negedge clk);
                        check("stray_ready", bus.i_ready, 1);
                        check("stray_req", bus.mem_req, 0);
                        check("stray_data", bus.data1, 0);
                        @(posedge clk); #1;
                    end
                    bus.mem_valid = 1'b0;
                    return;
                end
                if (gaps && $urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    check("gap_req", bus.mem_req, 1);
                    stalls++;
                    @(posedge clk); #1;
                end
                bus.mem_valid = 1'b1;
                bus.mem_rdata = mem[base + b];
                if (pass == 0 && b == redir_beat) begin
                    cur          = redir_a;
                    bus.address1 = cur;
                end
                if (pass == 0 && b == fence_beat) begin
                    bus.fence_i = 1'b1;
                    poison      = 1'b1;
                    model_flush();
                end
                @(negedge clk);
                check("beat_req", bus.mem_req, 1);
                check("beat_addr", bus.mem_addr, base);
                check("beat_ready", bus.i_ready, 0);
                stalls++;
                @(posedge clk); #1;
                bus.mem_valid = 1'b0;
                bus.fence_i   = 1'b0;
            end
            if (!poison) ref_base[line] = base;
        end
        n_checks++;
        n_fail++;
        $display("FAIL fetch_bound: address %0h never served", cur);
        bus.read_m1 = 1'b0;
    endtask

    task automatic fence_idle(input logic [15:0] a);
        bus.read_m1  = 1'b1;
        bus.address1 = a;
        bus.fence_i  = 1'b1;
        @(negedge clk);
        check("fence_idle_ready", bus.i_ready, 1);
        check("fence_idle_data", bus.data1, mem[a[7:0]]);
        exp_hits++;
        @(posedge clk); #1;
        bus.fence_i = 1'b0;
        bus.read_m1 = 1'b0;
        model_flush();
    endtask

    task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
        @(negedge clk);
        check({tag, "_hits"}, bus.hit_count, exp_hits);
        check({tag, "_misses"}, bus.miss_count, exp_misses);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        model_flush();
        reset_n       = 1'b0;
        bus.read_m1   = 1'b0;
        bus.address1  = '0;
        bus.fence_i   = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        #2;
        check("rst_idle_ready", bus.i_ready, 1);
        bus.read_m1 = 1'b1;
        #1;
        check("rst_read_ready", bus.i_ready, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        bus.read_m1 = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Cold miss with memory latency 2
        fetch(16'h0005, 2, 1'b0, -1, 16'h0, -1, -1, st);
        check("cold_stall", st, 7);
        for (int a = 4; a < 8; a++) begin
            fetch(16'(a), 0, 1'b0, -1, 16'h0, -1, -1, st);
            check("line_hit_stall", st, 0);
        end
        // Conflict on the same index
        fetch(16'h0024, 1, 1'b0, -1, 16'h0, -1, -1, st);
        fetch(16'h0004, 1, 1'b0, -1, 16'h0, -1, -1, st);
        check("conflict_refill", st, 6);
`ifdef ICACHE_STATS_EN
        @(negedge clk);
        check("conflict_miss_count", bus.miss_count, 3);
`endif
        // Redirect at beat 1
        fetch(16'h0010, 1, 1'b0, 1, 16'h0008, -1, -1, st);
        fetch(16'h0010, 0, 1'b0, -1, 16'h0, -1, -1, st);
        check("redirect_line_valid", st, 0);
        // Fence during fill
        fetch(16'h0030, 1, 1'b0, -1, 16'h0, 1, -1, st);
        check("fence_fill_stall", st, 12);
        fetch(16'h0004, 1, 1'b0, -1, 16'h0, -1, -1, st);
        check("fence_evicts", st, 6);
        // Fence in IDLE: the same-cycle lookup still hits
        fence_idle(16'h0004);
        fetch(16'h0004, 0, 1'b0, -1, 16'h0, -1, -1, st);
        check("fence_idle_evicts", st, 5);
        check_stats("directed");
        // Reset at beat 2
        fetch(16'h0014, 2, 1'b0, -1, 16'h0, -1, 2, st);
        fetch(16'h0004, 1, 1'b0, -1, 16'h0, -1, -1, st);
        check("post_reset_miss", st, 6);
        check_stats("post_reset");

        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            logic [15:0] ra;
            int          rb;
            int          fb;
            a  = 16'($urandom_range(0, 255));
            ra = 16'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LINE_WORDS - 1)) : -1;
            fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LINE_WORDS - 1)) : -1;
            fetch(a, int'($urandom_range(0, 3)), 1'b1, rb, ra, fb, -1, st);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        check_stats("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
